// File: rtl/udma_pkg.sv
// Shared uDMA constants: L2 data width, default arbiter ID-queue depth,
// and the L2 read arbiter FSM state type.
package udma_pkg;

    localparam int unsigned L2_DATA_WIDTH       = 32;
    localparam int unsigned UDMA_L2_ARB_MAX_OUT = 4;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } l2_arb_state_e;

endpackage

// File: rtl/udma_l2_arb_idfifo.sv
// Outstanding-response ID queue for the L2 read arbiter.
// Push and pop in the same cycle keep occupancy unchanged.
module udma_l2_arb_idfifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [AW:0]      cnt_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rd_q];
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_q <= rd_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/udma_l2_rd_arbiter.sv
// Round-robin arbiter sharing one L2 read-only port among N_REQ requesters.
// Optional macro UDMA_L2_ARB_PRIO_EN adds hi_prio_i (high-priority class).
module udma_l2_rd_arbiter
    import udma_pkg::*;
#(
    parameter int unsigned N_REQ           = 4,
    parameter int unsigned MAX_OUTSTANDING = UDMA_L2_ARB_MAX_OUT
) (
    input  logic                      sys_clk_i,
    input  logic                      sys_rst_i,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ-1:0][31:0]    addr_i,
`ifdef UDMA_L2_ARB_PRIO_EN
    input  logic [N_REQ-1:0]          hi_prio_i,
`endif
    output logic [N_REQ-1:0]          gnt_o,
    output logic [N_REQ-1:0]          rvalid_o,
    output logic [L2_DATA_WIDTH-1:0]  rdata_o,
    output logic                      L2_ro_req_o,
    input  logic                      L2_ro_gnt_i,
    output logic [31:0]               L2_ro_addr_o,
    input  logic                      L2_ro_rvalid_i,
    input  logic [L2_DATA_WIDTH-1:0]  L2_ro_rdata_i,
    output logic                      busy_o,
    output logic                      err_o
);

    localparam int unsigned IDW = $clog2(N_REQ);

    l2_arb_state_e  state_q;
    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;
    logic [IDW-1:0] win_q;
    logic           err_q;

    logic [N_REQ-1:0] cand;
    logic [IDW-1:0]   arb_win;
    logic [IDW-1:0]   win_sel;
    logic [IDW-1:0]   head_id;
    logic             q_full;
    logic             q_empty;
    logic             hs;
    logic             pop;

    // Scan requesters starting at the pointer; the high-priority class,
    // when present and requesting, replaces the candidate set entirely.
    always_comb begin
        logic [IDW:0] idx;
        logic         found;
        cand = req_i;
`ifdef UDMA_L2_ARB_PRIO_EN
        if (|(req_i & hi_prio_i)) begin
            cand = req_i & hi_prio_i;
        end
`endif
        arb_win = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = {1'b0, ptr_q} + (IDW+1)'(i);
            if (idx >= (IDW+1)'(N_REQ)) begin
                idx = idx - (IDW+1)'(N_REQ);
            end
            if (!found && cand[idx[IDW-1:0]]) begin
                found   = 1'b1;
                arb_win = idx[IDW-1:0];
            end
        end
    end

    assign win_sel      = (state_q == LOCK) ? win_q : arb_win;
    assign L2_ro_req_o  = ~sys_rst_i & ~q_full & ((state_q == LOCK) | (|req_i));
    assign L2_ro_addr_o = addr_i[win_sel];
    assign hs           = L2_ro_req_o & L2_ro_gnt_i;
    assign pop          = ~sys_rst_i & L2_ro_rvalid_i & ~q_empty;
    assign rdata_o      = L2_ro_rdata_i;
    assign busy_o       = ~sys_rst_i & ~q_empty;
    assign err_o        = err_q;
    assign ptr_d        = (win_sel == IDW'(N_REQ-1)) ? '0 : win_sel + 1'b1;

    always_comb begin
        gnt_o    = '0;
        rvalid_o = '0;
        if (hs) begin
            gnt_o[win_sel] = 1'b1;
        end
        if (pop) begin
            rvalid_o[head_id] = 1'b1;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_q <= ARB;
            ptr_q   <= '0;
            win_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ARB: begin
                    if (L2_ro_req_o && !L2_ro_gnt_i) begin
                        state_q <= LOCK;
                        win_q   <= arb_win;
                    end
                end
                LOCK: begin
                    if (hs) begin
                        state_q <= ARB;
                    end
                end
                default: state_q <= ARB;
            endcase
            if (hs) begin
                ptr_q <= ptr_d;
            end
            if (L2_ro_rvalid_i && q_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    udma_l2_arb_idfifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IDW)
    ) u_idfifo (
        .clk_i   (sys_clk_i),
        .rst_i   (sys_rst_i),
        .push_i  (hs),
        .data_i  (win_sel),
        .pop_i   (pop),
        .data_o  (head_id),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

endmodule

// File: tb/tb_udma_l2_rd_arbiter.sv
// Bench for udma_l2_rd_arbiter: directed scenarios with literal expectations,
// then random traffic, all cross-checked every cycle against a queue-based model.
module tb_udma_l2_rd_arbiter;
    import udma_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [3:0]               req = '0;
    logic [3:0][31:0]         addr = '0;
    logic                     gnt = 1'b0;
    logic                     rv_in = 1'b0;
    logic [L2_DATA_WIDTH-1:0] rdata_in = '0;
`ifdef UDMA_L2_ARB_PRIO_EN
    logic [3:0]               hi = '0;
`endif

    logic [3:0]               gnt_o;
    logic [3:0]               rvalid_o;
    logic [L2_DATA_WIDTH-1:0] rdata_o;
    logic                     l2_req;
    logic [31:0]              l2_addr;
    logic                     busy;
    logic                     err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    udma_l2_rd_arbiter #(
        .N_REQ           (4),
        .MAX_OUTSTANDING (4)
    ) dut (
        .sys_clk_i      (clk),
        .sys_rst_i      (rst),
        .req_i          (req),
        .addr_i         (addr),
`ifdef UDMA_L2_ARB_PRIO_EN
        .hi_prio_i      (hi),
`endif
        .gnt_o          (gnt_o),
        .rvalid_o       (rvalid_o),
        .rdata_o        (rdata_o),
        .L2_ro_req_o    (l2_req),
        .L2_ro_gnt_i    (gnt),
        .L2_ro_addr_o   (l2_addr),
        .L2_ro_rvalid_i (rv_in),
        .L2_ro_rdata_i  (rdata_in),
        .busy_o         (busy),
        .err_o          (err)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int     m_ptr = 0;
    int     m_pend = -1;   // requester presented but not yet granted
    int     m_q[$];
    bit     m_err = 1'b0;
    bit     s_hs = 0, s_pop = 0, s_want = 0, s_oob = 0;
    int     s_win = 0;

    always @(negedge clk) begin
        logic [3:0] e_gnt, e_rv;
        bit want, e_req;
        int w;
        want = 0; w = 0; e_req = 0; e_gnt = '0; e_rv = '0;
        s_hs = 0; s_pop = 0; s_oob = 0;
        if (!rst) begin
            if (m_pend >= 0) begin
                want = 1; w = m_pend;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (!want && req[(m_ptr + k) % 4]) begin
                        want = 1; w = (m_ptr + k) % 4;
                    end
                end
            end
            e_req = want && (m_q.size() < 4);
            s_hs  = e_req && gnt;
            s_pop = rv_in && (m_q.size() > 0);
            s_oob = rv_in && (m_q.size() == 0);
            if (s_hs)  e_gnt[w] = 1'b1;
            if (s_pop) e_rv[m_q[0]] = 1'b1;
        end
        s_want = e_req;
        s_win  = w;
        chk("l2_req", 64'(l2_req), 64'(e_req));
        chk("gnt_o", 64'(gnt_o), 64'(e_gnt));
        chk("rvalid_o", 64'(rvalid_o), 64'(e_rv));
        chk("busy_o", 64'(busy), 64'(!rst && m_q.size() > 0));
        chk("err_o", 64'(err), 64'(m_err));
        chk("rdata_o", 64'(rdata_o), 64'(rdata_in));
        if (e_req) chk("l2_addr", 64'(l2_addr), 64'(addr[w]));
    end

    always @(posedge clk) begin
        if (rst) begin
            m_ptr = 0; m_pend = -1; m_q.delete(); m_err = 1'b0;
        end else begin
            if (s_oob) m_err = 1'b1;
            if (s_pop) void'(m_q.pop_front());
            if (s_hs) begin
                m_q.push_back(s_win);
                m_ptr  = (s_win + 1) % 4;
                m_pend = -1;
            end else if (s_want) begin
                m_pend = s_win;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic rs, input logic [3:0] r, input logic g, input logic v);
        @(posedge clk);
        #1;
        rst = rs; req = r; gnt = g; rv_in = v;
        rdata_in = $urandom;
        for (int i = 0; i < 4; i++) addr[i] = $urandom;
        #2;
    endtask

    initial begin
        // reset holds outputs low even with traffic present
        drive(1, 4'b1111, 1, 0);
        chk("rst_l2_req", 64'(l2_req), 64'd0);
        drive(1, 4'b1111, 1, 1);
        chk("rst_gnt", 64'(gnt_o), 64'd0);
        chk("rst_rvalid", 64'(rvalid_o), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);

        // round-robin fairness
        drive(0, 4'b1111, 1, 0); chk("rr0", 64'(gnt_o), 64'b0001);
        drive(0, 4'b1111, 1, 1); chk("rr1", 64'(gnt_o), 64'b0010); chk("rr_rv0", 64'(rvalid_o), 64'b0001);
        drive(0, 4'b1111, 1, 1); chk("rr2", 64'(gnt_o), 64'b0100); chk("rr_rv1", 64'(rvalid_o), 64'b0010);
        drive(0, 4'b1111, 1, 1); chk("rr3", 64'(gnt_o), 64'b1000); chk("rr_rv2", 64'(rvalid_o), 64'b0100);
        drive(0, 4'b1111, 1, 1); chk("rr4", 64'(gnt_o), 64'b0001); chk("rr_rv3", 64'(rvalid_o), 64'b1000);
        drive(0, 4'b0000, 0, 1); chk("rr_rv4", 64'(rvalid_o), 64'b0001);
        drive(0, 4'b0000, 0, 0); chk("rr_idle_busy", 64'(busy), 64'd0);

        // lock stability (pointer back at 0 so an unlocked arbiter would pick 0)
        drive(1, 4'b0000, 0, 0);
        for (int c = 0; c < 3; c++) begin
            drive(0, 4'b0100, 0, 0);
            chk("lock_req", 64'(l2_req), 64'd1);
            chk("lock_addr", 64'(l2_addr), 64'(addr[2]));
        end
        drive(0, 4'b0101, 1, 0); chk("lock_first", 64'(gnt_o), 64'b0100);
        drive(0, 4'b0101, 1, 0); chk("lock_second", 64'(gnt_o), 64'b0001);
        drive(0, 4'b0000, 0, 1); chk("lock_rv2", 64'(rvalid_o), 64'b0100);
        drive(0, 4'b0000, 0, 1); chk("lock_rv0", 64'(rvalid_o), 64'b0001);
        drive(0, 4'b0000, 0, 0);

        // queue full (pointer is 1 here)
        drive(0, 4'b1111, 1, 0); chk("full_g1", 64'(gnt_o), 64'b0010);
        drive(0, 4'b1111, 1, 0); chk("full_g2", 64'(gnt_o), 64'b0100);
        drive(0, 4'b1111, 1, 0); chk("full_g3", 64'(gnt_o), 64'b1000);
        drive(0, 4'b1111, 1, 0); chk("full_g0", 64'(gnt_o), 64'b0001);
        drive(0, 4'b1111, 1, 0); chk("full_block", 64'(l2_req), 64'd0); chk("full_gnt", 64'(gnt_o), 64'd0);
        drive(0, 4'b1111, 1, 1); chk("full_pop_req", 64'(l2_req), 64'd0); chk("full_pop_rv", 64'(rvalid_o), 64'b0010);
        drive(0, 4'b1111, 1, 0); chk("full_reen", 64'(l2_req), 64'd1); chk("full_reen_gnt", 64'(gnt_o), 64'b0010);
        drive(0, 4'b0000, 0, 1); chk("drain2", 64'(rvalid_o), 64'b0100);
        drive(0, 4'b0000, 0, 1); chk("drain3", 64'(rvalid_o), 64'b1000);
        drive(0, 4'b0000, 0, 1); chk("drain0", 64'(rvalid_o), 64'b0001);
        drive(0, 4'b0000, 0, 1); chk("drain1", 64'(rvalid_o), 64'b0010);

        // out-of-band rvalid
        drive(0, 4'b0000, 0, 1); chk("oob_rv", 64'(rvalid_o), 64'd0); chk("oob_err_now", 64'(err), 64'd0);
        drive(0, 4'b0000, 0, 0); chk("oob_err_set", 64'(err), 64'd1);
        drive(0, 4'b0000, 0, 1); chk("oob_err_hold", 64'(err), 64'd1);
        drive(0, 4'b0000, 1, 0); chk("oob_err_hold2", 64'(err), 64'd1);
        drive(1, 4'b0000, 0, 0);
        drive(0, 4'b0000, 0, 0); chk("oob_err_clr", 64'(err), 64'd0);

        // reset mid-operation
        drive(0, 4'b0011, 1, 0); chk("mid_g0", 64'(gnt_o), 64'b0001);
        drive(0, 4'b0011, 1, 0); chk("mid_g1", 64'(gnt_o), 64'b0010);
        drive(0, 4'b0000, 0, 0); chk("mid_busy", 64'(busy), 64'd1);
        drive(1, 4'b0000, 0, 0); chk("mid_rst_busy", 64'(busy), 64'd0);
        drive(0, 4'b0000, 0, 0); chk("mid_post_busy", 64'(busy), 64'd0);
        drive(0, 4'b1111, 0, 0); chk("mid_ptr0", 64'(l2_addr), 64'(addr[0]));
        drive(0, 4'b0000, 0, 1); chk("mid_late_rv", 64'(rvalid_o), 64'd0);
        drive(0, 4'b0000, 0, 0); chk("mid_late_err", 64'(err), 64'd1);
        drive(1, 4'b0000, 0, 0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom % 100) == 0, 4'($urandom), ($urandom % 10) < 6, ($urandom % 10) < 4);
        end
        drive(0, 4'b0000, 0, 0);
        @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
